// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, FSM state and request type for regfile write-port sharing
package regfile_pkg;
  localparam int REG_ADDR_W = 6;
  localparam int NUM_REGS = 32;
  typedef enum logic {IDLE, SPLIT_HI} state_e;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] d;
    logic [15:0] rd;
    logic word;
  } req_t;
endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant; last winner loses the next tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
  assign last_d = (en_i & |req_i) ? gnt_o[1] : last_q;
  // remember who won the last accepted request; reset favours requester 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: shares the regfile write port between ALU and LSU; REGFILE_WR_ARB_STATS_EN adds stall counters
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_d,
  input  logic [15:0]       req0_Rd,
  input  logic              req0_word,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_d,
  input  logic [15:0]       req1_Rd,
  input  logic              req1_word,
  input  logic [ADDR_W-1:0] rd_a,
  input  logic [ADDR_W-1:0] rd_b,
  output logic              hazard,
  output logic              illegal,
  output logic              write,
  output logic              write_word,
  output logic [ADDR_W-1:0] d,
`ifdef REGFILE_WR_ARB_STATS_EN
  output logic [15:0]       Rd,
  output logic [15:0]       stall0_cnt,
  output logic [15:0]       stall1_cnt
`else
  output logic [15:0]       Rd
`endif
);
  localparam logic [ADDR_W:0] NREG = NUM_REGS[ADDR_W:0];
  state_e state_q, state_d;
  logic write_q, write_d, word_q, word_d, ill_q, ill_d;
  logic [ADDR_W-1:0] d_q, d_d, hi_d_q, hi_d_d;
  logic [15:0] rd_q, rd_d;
  logic [7:0] hi_data_q, hi_data_d;
  logic [1:0] gnt;
  logic idle, acc, bad;
  logic [ADDR_W:0] d_inc;
  req_t r;

  assign idle = state_q == IDLE;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (reset),
    .en_i  (idle),
    .req_i ({req1_valid, req0_valid}),
    .gnt_o (gnt)
  );
  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];
  assign acc = idle & |gnt;
  assign r = gnt[1] ? '{d: req1_d, rd: req1_Rd, word: req1_word} : '{d: req0_d, rd: req0_Rd, word: req0_word};
  assign bad = {1'b0, r.d} >= NREG;
  assign d_inc = {1'b0, r.d} + (ADDR_W+1)'(1);

  // next write-port contents: high byte of a split, else the accepted request
  always_comb begin
    state_d = IDLE;
    write_d = 1'b0;
    word_d = 1'b0;
    ill_d = 1'b0;
    d_d = d_q;
    rd_d = rd_q;
    hi_d_d = hi_d_q;
    hi_data_d = hi_data_q;
    if (!idle) begin
      write_d = 1'b1;
      d_d = hi_d_q;
      rd_d = {8'h00, hi_data_q};
    end else if (acc && bad) begin
      ill_d = 1'b1;
    end else if (acc) begin
      write_d = 1'b1;
      d_d = r.d;
      word_d = r.word & ~r.d[0];
      rd_d = word_d ? r.rd : {8'h00, r.rd[7:0]};
      if (r.word && r.d[0]) begin
        ill_d = d_inc == NREG;
        state_d = ill_d ? IDLE : SPLIT_HI;
        hi_d_d = d_inc[ADDR_W-1:0];
        hi_data_d = r.rd[15:8];
      end
    end
  end

  // register the write port, split state and pending high byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      word_q <= 1'b0;
      ill_q <= 1'b0;
      d_q <= '0;
      rd_q <= '0;
      hi_d_q <= '0;
      hi_data_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      word_q <= word_d;
      ill_q <= ill_d;
      d_q <= d_d;
      rd_q <= rd_d;
      hi_d_q <= hi_d_d;
      hi_data_q <= hi_data_d;
    end
  end

  assign write = write_q;
  assign write_word = word_q;
  assign d = d_q;
  assign Rd = rd_q;
  assign illegal = ill_q;
  assign hazard = !idle & ((rd_a[ADDR_W-1:1] == hi_d_q[ADDR_W-1:1]) | (rd_b == hi_d_q));

`ifdef REGFILE_WR_ARB_STATS_EN
  logic [15:0] s0_q, s0_d, s1_q, s1_d;
  assign s0_d = (req0_valid & ~req0_ready & ~&s0_q) ? s0_q + 16'd1 : s0_q;
  assign s1_d = (req1_valid & ~req1_ready & ~&s1_q) ? s1_q + 16'd1 : s1_q;
  // saturating count of cycles each requester waited
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end
  assign stall0_cnt = s0_q;
  assign stall1_cnt = s1_q;
`endif
endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Shares the regfile's single write port (write, write_word, d, Rd) between two requesters: the ALU result path (req 0) and the load/store data path (req 1).
- Each requester uses a valid/ready handshake; the block registers the granted request onto the regfile write port.
- Unaligned 16-bit writes (odd d) are split into two byte writes on consecutive cycles.
- Flags read hazards on the not-yet-written high byte of a split.

Parameters:
- NUM_REGS, 32, byte registers addressable; d >= NUM_REGS is illegal.
- ADDR_W, 6, register address width (matches regfile a/b/d).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  ALU write request.
- req0_ready  out  1  ALU request accepted when valid & ready.
- req0_d  in  6  target register.
- req0_Rd  in  16  write data.
- req0_word  in  1  16-bit write.
- req1_valid / req1_ready / req1_d / req1_Rd / req1_word  same as req0, for LSU.
- rd_a  in  6  regfile read port A address (16-bit read).
- rd_b  in  6  regfile read port B address (8-bit read).
- hazard  out  1  a read on rd_a/rd_b targets a pending split high byte; the consumer must stall.
- illegal  out  1  one-cycle pulse: an accepted request had an out-of-range d.
- write  out  1  to regfile.write.
- write_word  out  1  to regfile.write_word.
- d  out  6  to regfile.d.
- Rd  out  16  to regfile.Rd.

Behaviour:
- Reset (async, any cycle, including mid-split):
  - Outputs: write=0, write_word=0, d=0, Rd=0, illegal=0, hazard=0.
  - State: state=IDLE, last_grant=1 (req0 wins first).
  - A pending split high byte is discarded.
- FSM states: IDLE, SPLIT_HI.
- IDLE:
  - req0_ready = req1_ready = 1 only for the granted requester, round-robin.
  - If both requesters are valid, grant the one != last_grant. If one is valid, grant it.
  - last_grant updates on every accept.
- Latency:
  - An accept in cycle N drives write=1 with the registered d/Rd/write_word in cycle N+1.
  - write is a one-cycle pulse per byte/word write.
  - Back-to-back accepts give write=1 on consecutive cycles.
- Aligned word (word=1, d[0]=0): one cycle with write_word=1, d=d, Rd=Rd.
- Byte (word=0): one cycle with write_word=0, Rd={8'h00,Rd[7:0]}.
- Unaligned word (word=1, d[0]=1):
  - Cycle N+1: byte write of d with Rd[7:0]. Enter SPLIT_HI, holding hi_d=d+1 and hi_data=Rd[15:8].
  - Cycle N+2: byte write of hi_d with hi_data. Return to IDLE.
  - Both readies are 0 in SPLIT_HI, so no accept can occur in cycle N+1.
  - d+1 == NUM_REGS (d=31): only the low byte is written, no SPLIT_HI, illegal pulses in N+1.
- Illegal d (d >= NUM_REGS): the request is accepted (handshake completes), write stays 0, illegal=1 in cycle N+1.
- Hazard (combinational):
  - hazard = (state==SPLIT_HI) & ((rd_a[5:1]==hi_d[5:1]) | (rd_b==hi_d)).
  - No hazard in IDLE; the regfile's own a==d / b==d bypass covers the write in flight.
- A requester must hold valid, d, Rd and word stable until accepted. Dropping valid before accept is allowed and leaves no side effect.

Optional Feature:
- REGFILE_WR_ARB_STATS_EN defined adds output ports stall0_cnt[15:0] and stall1_cnt[15:0].
  - Each counts cycles its requester had valid=1 and ready=0.
  - Saturating at 16'hFFFF; cleared by reset.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg holds:
  - Constants REG_ADDR_W=6 and NUM_REGS=32.
  - FSM state typedef {IDLE, SPLIT_HI}.
  - A request struct {d, Rd, word}.
- One sub-module, rr_arb2: 2-way round-robin grant with last_grant state, reused by future read-port sharing.

Test Plan:
- Reset mid-split: req0 d=5 word Rd=16'hBEEF accepted, reset asserted in N+1 -> write=0 immediately, no write of d=6, state IDLE.
- Simultaneous: req0 d=2 Rd=16'h0011 and req1 d=4 Rd=16'h0022 held valid from cycle 0 -> write d=2 at cycle 1, d=4 at cycle 2; then req0 alone wins next.
- Unaligned split: req1 d=9 word Rd=16'hA55A -> cycle N+1 write d=9 Rd=16'h005A; cycle N+2 write d=10 Rd=16'h00A5.
  - During N+1, rd_b=10 gives hazard=1, rd_a=10 gives hazard=1, rd_a=8 gives hazard=0.
  - Both readies are 0 in N+1.
- Boundary: req0 d=31 word Rd=16'h1234 -> single write d=31 Rd=16'h0034, illegal=1 in N+1, no second write.
- Illegal: req1 d=40 byte -> ready=1 and accepted, write stays 0, illegal pulses once.
- Stats (with REGFILE_WR_ARB_STATS_EN): both requesters valid for 10 cycles with byte writes -> stall0_cnt=5, stall1_cnt=5 ±1 depending on first grant.
